// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 coprocessor sequencer.
package sha256_ctrl_pkg;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned DIGEST_W    = 256;
   localparam int unsigned BLOCK_W     = BLOCK_WORDS * WORD_W;

   localparam logic MODE_SHA_256 = 1'b1;
   localparam logic MODE_SHA_224 = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ACK,
      ST_RUN
   } state_e;

   // Word 0 is the most significant word of the block.
   function automatic int unsigned word_lsb(input int unsigned idx);
      return (BLOCK_WORDS - 1 - idx) * WORD_W;
   endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 message word register file with a flat 512-bit big-endian-word read port.
// Write lands on the clock edge; the read port reflects stored words continuously.
module sha256_block_buf
   import sha256_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [3:0]          wr_addr,
   input  logic [WORD_W-1:0]   wr_data,
   output logic [BLOCK_W-1:0]  block
);

   logic [WORD_W-1:0] mem_q [BLOCK_WORDS];
   logic [WORD_W-1:0] mem_d [BLOCK_WORDS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      block = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
         block[word_lsb(i) +: WORD_W] = mem_q[i];
      end
   end

endmodule

// File: rtl/sha256_ctrl.sv
// Sequencer between the host word/command interface and sha256_core; optional SHA256_CTRL_CYCLE_CNT_EN adds cycle_cnt.
// Latency: accept at cycle 0, init/next at cycle 1 (if core ready), done the cycle after the core returns ready.
// Backpressure: cmd_ready low while busy; commands then are ignored and writes are dropped with err set.
module sha256_ctrl #(
   parameter logic        MODE_SHA_256  = 1'b1,
   parameter int unsigned BUSY_WAIT_MAX = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [3:0]    wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          cmd_valid,
   input  logic          cmd_first,
   output logic          cmd_ready,
   output logic          done,
   output logic          busy,
   output logic          err,
   output logic [255:0]  digest,
   output logic          core_init,
   output logic          core_next,
   output logic          core_mode,
   output logic [511:0]  core_block,
   input  logic          core_ready,
   input  logic [255:0]  core_digest,
   input  logic          core_digest_valid
`ifdef SHA256_CTRL_CYCLE_CNT_EN
   ,
   output logic [15:0]   cycle_cnt
`endif
);

   import sha256_ctrl_pkg::*;

   localparam int unsigned WAIT_W = $clog2(BUSY_WAIT_MAX + 1);

   state_e               state_q, state_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [DIGEST_W-1:0]  digest_q, digest_d;
   logic                 init_q, init_d;
   logic                 next_q, next_d;
   logic                 first_q, first_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 accept;

   assign accept = (state_q == ST_IDLE) && cmd_valid;

   sha256_block_buf u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en && (state_q == ST_IDLE)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .block   (core_block)
   );

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      done_d      = 1'b0;
      busy_d      = busy_q;
      err_d       = err_q;
      digest_d    = digest_q;
      init_d      = 1'b0;
      next_d      = 1'b0;
      first_d     = first_q;
      wait_d      = wait_q;

      if (wr_en && busy_q) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               busy_d      = 1'b1;
               err_d       = 1'b0;
               cmd_ready_d = 1'b0;
               first_d     = cmd_first;
               wait_d      = '0;
               // Skip ISSUE when the core is already ready so the pulse lands in cycle 1.
               if (core_ready) begin
                  init_d  = cmd_first;
                  next_d  = !cmd_first;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (core_ready) begin
               init_d  = first_q;
               next_d  = !first_q;
               wait_d  = '0;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!core_ready) begin
               state_d = ST_RUN;
            end else if (wait_q == WAIT_W'(BUSY_WAIT_MAX - 1)) begin
               err_d       = 1'b1;
               busy_d      = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (core_ready && core_digest_valid) begin
               digest_d    = core_digest;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         digest_q    <= '0;
         init_q      <= 1'b0;
         next_q      <= 1'b0;
         first_q     <= 1'b0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         digest_q    <= digest_d;
         init_q      <= init_d;
         next_q      <= next_d;
         first_q     <= first_d;
         wait_q      <= wait_d;
      end
   end

`ifdef SHA256_CTRL_CYCLE_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (busy_q && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycle_cnt = cnt_q;
`endif

   assign cmd_ready = cmd_ready_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign digest    = digest_q;
   assign core_init = init_q;
   assign core_next = next_q;
   assign core_mode = MODE_SHA_256;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Bench for sha256_ctrl: stub core returning known FIPS digests, digest scoreboard, error/reset/timeout cases.
module tb_sha256_ctrl;

   localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] ABC_PART = {32'h61626380, {15{32'h0}}};
   localparam logic [255:0] ABC_DIG =
      256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
   localparam logic [511:0] M1_BLK = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] M2_BLK = {{15{32'h0}}, 32'h000001C0};
   localparam logic [255:0] H1_DIG =
      256'h85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A;
   localparam logic [255:0] H2_DIG =
      256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
   localparam int RUN_CYC = 6;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_en, cmd_valid, cmd_first;
   logic [3:0]    wr_addr;
   logic [31:0]   wr_data;
   logic          cmd_ready, done, busy, err;
   logic [255:0]  digest;
   logic          core_init, core_next, core_mode;
   logic [511:0]  core_block;
   logic          core_ready, core_digest_valid;
   logic [255:0]  core_digest;
`ifdef SHA256_CTRL_CYCLE_CNT_EN
   logic [15:0]   cycle_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_init  = 0;
   int n_next  = 0;
   int n_both  = 0;
   int n_done  = 0;
   int busy_cycles = 0;
   logic stub_stuck = 1'b0;
   logic [255:0] sb[$];

   always #5 clk = ~clk;

   sha256_ctrl dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .cmd_valid         (cmd_valid),
      .cmd_first         (cmd_first),
      .cmd_ready         (cmd_ready),
      .done              (done),
      .busy              (busy),
      .err               (err),
      .digest            (digest),
      .core_init         (core_init),
      .core_next         (core_next),
      .core_mode         (core_mode),
      .core_block        (core_block),
      .core_ready        (core_ready),
      .core_digest       (core_digest),
      .core_digest_valid (core_digest_valid)
`ifdef SHA256_CTRL_CYCLE_CNT_EN
      ,
      .cycle_cnt         (cycle_cnt)
`endif
   );

   function automatic logic [255:0] stub_hash(input logic [511:0] blk, input logic is_init,
                                              input logic [255:0] prev);
      if (is_init && blk == ABC_BLK) return ABC_DIG;
      if (is_init && blk == M1_BLK) return H1_DIG;
      if (!is_init && blk == M2_BLK && prev == H1_DIG) return H2_DIG;
      return blk[511:256] ^ blk[255:0] ^ (is_init ? 256'h0 : prev);
   endfunction

   // Stub core: goes busy the cycle after init/next, returns ready+digest RUN_CYC cycles later.
   logic [255:0] pend;
   int stub_cnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_ready        <= 1'b1;
         core_digest_valid <= 1'b0;
         core_digest       <= '0;
         pend              <= '0;
         stub_cnt          <= 0;
      end else if (core_init || core_next) begin
         if (!stub_stuck) begin
            core_ready        <= 1'b0;
            core_digest_valid <= 1'b0;
            stub_cnt          <= RUN_CYC;
            pend              <= stub_hash(core_block, core_init, core_digest);
         end
      end else if (!core_ready) begin
         if (stub_cnt == 0) begin
            core_ready        <= 1'b1;
            core_digest_valid <= 1'b1;
            core_digest       <= pend;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (core_init) n_init++;
      if (core_next) n_next++;
      if (core_init && core_next) n_both++;
      if (busy) busy_cycles++;
      if (done) begin
         n_done++;
         chk("sb_nonempty_at_done", 256'(sb.size() != 0), 256'd1);
         if (sb.size() != 0) chk("digest", digest, sb.pop_front());
      end
   end

   task automatic write_block(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(i);
         wr_data = blk[511 - 32*i -: 32];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic issue(input logic first, input logic [255:0] exp, input logic push,
                        input logic wa_en, input logic [3:0] wa, input logic [31:0] wd);
      int k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_before_issue", 256'(cmd_ready), 256'd1);
      cmd_valid   = 1'b1;
      cmd_first   = first;
      wr_en       = wa_en;
      wr_addr     = wa;
      wr_data     = wd;
      busy_cycles = 0;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_first = !first;
      wr_en     = 1'b0;
      if (push) sb.push_back(exp);
      chk("busy_after_accept", 256'(busy), 256'd1);
      chk("cmd_ready_after_accept", 256'(cmd_ready), 256'd0);
      chk("err_cleared_on_accept", 256'(err), 256'd0);
      chk("init_cycle1", 256'(core_init), 256'(first));
      chk("next_cycle1", 256'(core_next), 256'(!first));
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", 256'(done), 256'd1);
   endtask

   task automatic wait_core_busy();
      int k = 0;
      while (core_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("core_went_busy", 256'(core_ready), 256'd0);
   endtask

   initial begin
      int i0, n0, d0, k;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, n0, d0, k;
      reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cmd_valid = 1'b0; cmd_first = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 256'(cmd_ready), 256'd1);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);
      chk("rst_err", 256'(err), 256'd0);
      chk("rst_digest", digest, 256'd0);
      chk("rst_core_init", 256'(core_init), 256'd0);
      chk("rst_core_next", 256'(core_next), 256'd0);
      chk("rst_core_mode", 256'(core_mode), 256'd1);
      chk("rst_core_block", core_block[255:0], 256'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // "abc" single block
      write_block(ABC_BLK);
      chk("abc_block_hi", core_block[511:256], ABC_BLK[511:256]);
      chk("abc_block_lo", core_block[255:0], ABC_BLK[255:0]);
      i0 = n_init; n0 = n_next; d0 = n_done;
      issue(1'b1, ABC_DIG, 1'b1, 1'b0, 4'd0, 32'd0);
      wait_done();
      chk("abc_init_count", 256'(n_init - i0), 256'd1);
      chk("abc_next_count", 256'(n_next - n0), 256'd0);
      chk("abc_err", 256'(err), 256'd0);
      @(negedge clk);
      chk("abc_done_once", 256'(n_done - d0), 256'd1);
      chk("abc_busy_low", 256'(busy), 256'd0);
`ifdef SHA256_CTRL_CYCLE_CNT_EN
      chk("cycle_cnt_matches", 256'(cycle_cnt), 256'(busy_cycles));
      chk("cycle_cnt_nonzero", 256'(cycle_cnt != 16'd0), 256'd1);
      repeat (3) @(negedge clk);
      chk("cycle_cnt_holds", 256'(cycle_cnt), 256'(busy_cycles));
`endif

      // Two-block message chained with next
      write_block(M1_BLK);
      issue(1'b1, H1_DIG, 1'b1, 1'b0, 4'd0, 32'd0);
      wait_done();
      @(negedge clk);
      write_block(M2_BLK);
      i0 = n_init; n0 = n_next;
      issue(1'b0, H2_DIG, 1'b1, 1'b0, 4'd0, 32'd0);
      wait_done();
      chk("chain_init_count", 256'(n_init - i0), 256'd0);
      chk("chain_next_count", 256'(n_next - n0), 256'd1);

      // Write during RUN is dropped and flags err
      @(negedge clk);
      write_block(ABC_BLK);
      issue(1'b1, ABC_DIG, 1'b1, 1'b0, 4'd0, 32'd0);
      wait_core_busy();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
      @(negedge clk);
      wr_en = 1'b0;
      chk("err_on_busy_write", 256'(err), 256'd1);
      wait_done();
      chk("err_sticky_after_done", 256'(err), 256'd1);
      chk("word3_untouched", 256'(core_block[415:384]), 256'd0);
      // Same-cycle write and command: the new word must be in the issued block
      @(negedge clk);
      write_block(ABC_PART);
      issue(1'b1, ABC_DIG, 1'b1, 1'b1, 4'd15, 32'h00000018);
      wait_done();

      // Reset two cycles into RUN
      @(negedge clk);
      write_block(ABC_BLK);
      d0 = n_done;
      issue(1'b1, ABC_DIG, 1'b0, 1'b0, 4'd0, 32'd0);
      wait_core_busy();
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 256'(busy), 256'd0);
      chk("midrst_digest", digest, 256'd0);
      chk("midrst_cmd_ready", 256'(cmd_ready), 256'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("midrst_no_done", 256'(n_done - d0), 256'd0);
      write_block(ABC_BLK);
      issue(1'b1, ABC_DIG, 1'b1, 1'b0, 4'd0, 32'd0);
      wait_done();

      // Core never drops ready: ACK timeout
      @(negedge clk);
      stub_stuck = 1'b1;
      d0 = n_done;
      issue(1'b1, ABC_DIG, 1'b0, 1'b0, 4'd0, 32'd0);
      k = 0;
      while (!err && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("ack_timeout_cycles", 256'(k), 256'd4);
      chk("ack_timeout_err", 256'(err), 256'd1);
      chk("ack_timeout_idle", 256'(cmd_ready), 256'd1);
      chk("ack_timeout_busy", 256'(busy), 256'd0);
      repeat (10) @(negedge clk);
      chk("ack_timeout_no_done", 256'(n_done - d0), 256'd0);
      stub_stuck = 1'b0;

      chk("init_next_exclusive", 256'(n_both), 256'd0);
      chk("scoreboard_drained", 256'(sb.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
